// File: rtl/complex_addsub_pipe.sv
// complex_addsub_pipe
// Pipelined complex butterfly adder/subtractor for the FFT datapath.
// Each accepted beat carries two complex samples A and B. The block
// returns A+B and A-B. A per-beat scale flag chooses between two modes:
// halving, with truncation or rounding, or full scale with saturation.
// Beats that saturated are flagged, and a saturating counter feeds the
// block-scaling controller.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_valid, o_ready_in   input handshake (o_ready_in is combinational)
//   i_scale               1 = halve result, 0 = full scale with clamp
//   i_re_a/i_im_a         sample A (signed, DW bits)
//   i_re_b/i_im_b         sample B (signed, DW bits)
//   o_valid, i_ready      output handshake
//   o_re_sum/o_im_sum     A+B
//   o_re_dif/o_im_dif     A-B
//   o_ovf                 one or more of the four results clamped on this beat
//   i_clr_cnt             synchronous clear of the overflow counter
//   o_ovf_cnt             saturating count of delivered beats with o_ovf=1
module complex_addsub_pipe #(
  parameter int DW    = 16,
  parameter int PIPE  = 2,
  parameter int ROUND = 0,
  parameter int OCW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready_in,
  input  logic                 i_scale,
  input  logic signed [DW-1:0] i_re_a,
  input  logic signed [DW-1:0] i_im_a,
  input  logic signed [DW-1:0] i_re_b,
  input  logic signed [DW-1:0] i_im_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [DW-1:0] o_re_sum,
  output logic signed [DW-1:0] o_im_sum,
  output logic signed [DW-1:0] o_re_dif,
  output logic signed [DW-1:0] o_im_dif,
  output logic                 o_ovf,
  input  logic                 i_clr_cnt,
  output logic [OCW-1:0]       o_ovf_cnt
);

  localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam logic [OCW-1:0]       CNT_MAX = {OCW{1'b1}};

  // Sign-extended sum or difference in DW+1 bits, which cannot overflow.
  function automatic logic signed [DW:0] addsub(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b,
                                                input logic sub);
    logic signed [DW:0] ae;
    logic signed [DW:0] be;
    ae = {a[DW-1], a};
    be = {b[DW-1], b};
    return sub ? (ae - be) : (ae + be);
  endfunction

  // Reduce a DW+1 bit result to DW bits.
  // The halved path cannot overflow. Rounding is done in DW+2 bits
  // so that the +1 on the largest sum does not wrap.
  function automatic logic signed [DW-1:0] shrink(input logic signed [DW:0] s,
                                                  input logic scl);
    logic signed [DW+1:0] t;
    logic signed [DW-1:0] r;
    t = {s[DW], s} + (DW+2)'(1);
    if (scl) begin
      r = (ROUND != 0) ? t[DW:1] : s[DW:1];
    end else if (s[DW] != s[DW-1]) begin
      r = s[DW] ? MINV : MAXV;
    end else begin
      r = s[DW-1:0];
    end
    return r;
  endfunction

  // Clamp event: full-scale mode and the top two bits disagree.
  function automatic logic clamped(input logic signed [DW:0] s, input logic scl);
    return ~scl & (s[DW] ^ s[DW-1]);
  endfunction

  logic en;
  logic signed [DW:0] re_s, im_s, re_d, im_d;

  logic                 vld_p    [PIPE];
  logic signed [DW-1:0] re_sum_p [PIPE];
  logic signed [DW-1:0] im_sum_p [PIPE];
  logic signed [DW-1:0] re_dif_p [PIPE];
  logic signed [DW-1:0] im_dif_p [PIPE];
  logic                 ovf_p    [PIPE];
  logic [OCW-1:0]       cnt;
  logic                 inc;

  // One global enable stalls the whole pipe when the output is full and blocked.
  assign en         = i_ready | ~o_valid;
  assign o_ready_in = en;

  always_comb begin
    re_s = addsub(i_re_a, i_re_b, 1'b0);
    im_s = addsub(i_im_a, i_im_b, 1'b0);
    re_d = addsub(i_re_a, i_re_b, 1'b1);
    im_d = addsub(i_im_a, i_im_b, 1'b1);
  end

  // Data moves only with a valid beat. A bubble therefore leaves the last
  // beat's values in place downstream, so the outputs hold while o_valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) begin
        vld_p[i]    <= 1'b0;
        re_sum_p[i] <= '0;
        im_sum_p[i] <= '0;
        re_dif_p[i] <= '0;
        im_dif_p[i] <= '0;
        ovf_p[i]    <= 1'b0;
      end
    end else if (en) begin
      // stage p0: arithmetic, scaling and clamp on the accepted beat
      vld_p[0] <= i_valid;
      if (i_valid) begin
        re_sum_p[0] <= shrink(re_s, i_scale);
        im_sum_p[0] <= shrink(im_s, i_scale);
        re_dif_p[0] <= shrink(re_d, i_scale);
        im_dif_p[0] <= shrink(im_d, i_scale);
        ovf_p[0]    <= clamped(re_s, i_scale) | clamped(im_s, i_scale) |
                       clamped(re_d, i_scale) | clamped(im_d, i_scale);
      end
      // stages p1..pN: delay line, with the flag kept beside its beat
      for (int i = 1; i < PIPE; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) begin
          re_sum_p[i] <= re_sum_p[i-1];
          im_sum_p[i] <= im_sum_p[i-1];
          re_dif_p[i] <= re_dif_p[i-1];
          im_dif_p[i] <= im_dif_p[i-1];
          ovf_p[i]    <= ovf_p[i-1];
        end
      end
    end
  end

  assign o_valid  = vld_p[PIPE-1];
  assign o_re_sum = re_sum_p[PIPE-1];
  assign o_im_sum = im_sum_p[PIPE-1];
  assign o_re_dif = re_dif_p[PIPE-1];
  assign o_im_dif = im_dif_p[PIPE-1];
  assign o_ovf    = ovf_p[PIPE-1];

  // Count a beat only when it is delivered. A clear that arrives with an
  // increment sets the counter to 1, so that beat is not lost.
  assign inc = o_valid & i_ready & o_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (i_clr_cnt) begin
      cnt <= inc ? OCW'(1) : '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + OCW'(1);
    end
  end

  assign o_ovf_cnt = cnt;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
module tb_complex_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0, i_scale = 1'b0, i_ready = 1'b1, i_clr_cnt = 1'b0;
  logic signed [15:0] i_re_a = '0, i_im_a = '0, i_re_b = '0, i_im_b = '0;

  logic o_ready_in, o_valid, o_ovf;
  logic signed [15:0] o_re_sum, o_im_sum, o_re_dif, o_im_dif;
  logic [3:0] o_ovf_cnt;

  logic o_ready_in_r, o_valid_r, o_ovf_r;
  logic signed [15:0] o_re_sum_r, o_im_sum_r, o_re_dif_r, o_im_dif_r;
  logic [3:0] o_ovf_cnt_r;

  logic [63:0] out_now;
  assign out_now = {o_re_sum, o_im_sum, o_re_dif, o_im_dif};

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  complex_addsub_pipe #(.DW(16), .PIPE(2), .ROUND(0), .OCW(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready_in(o_ready_in),
    .i_scale(i_scale), .i_re_a(i_re_a), .i_im_a(i_im_a), .i_re_b(i_re_b),
    .i_im_b(i_im_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_re_sum(o_re_sum), .o_im_sum(o_im_sum), .o_re_dif(o_re_dif),
    .o_im_dif(o_im_dif), .o_ovf(o_ovf), .i_clr_cnt(i_clr_cnt),
    .o_ovf_cnt(o_ovf_cnt));

  complex_addsub_pipe #(.DW(16), .PIPE(2), .ROUND(1), .OCW(4)) dut_r (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready_in(o_ready_in_r),
    .i_scale(i_scale), .i_re_a(i_re_a), .i_im_a(i_im_a), .i_re_b(i_re_b),
    .i_im_b(i_im_b), .o_valid(o_valid_r), .i_ready(i_ready),
    .o_re_sum(o_re_sum_r), .o_im_sum(o_im_sum_r), .o_re_dif(o_re_dif_r),
    .o_im_dif(o_im_dif_r), .o_ovf(o_ovf_r), .i_clr_cnt(i_clr_cnt),
    .o_ovf_cnt(o_ovf_cnt_r));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [15:0] ra, input logic signed [15:0] ia,
                       input logic signed [15:0] rb, input logic signed [15:0] ib,
                       input logic sc);
    i_re_a = ra; i_im_a = ia; i_re_b = rb; i_im_b = ib; i_scale = sc;
    i_valid = 1'b1;
  endtask

  // One beat with i_ready=1. On return the beat sits on the outputs.
  task automatic beat(input logic signed [15:0] ra, input logic signed [15:0] ia,
                      input logic signed [15:0] rb, input logic signed [15:0] ib,
                      input logic sc);
    drive(ra, ia, rb, ib, sc);
    tick();
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", o_valid); end
    vec++; if (out_now !== 64'd0) begin bad++; $display("FAIL rst_data got %h want 0", out_now); end
    vec++; if (o_ovf !== 1'b0 || o_ovf_cnt !== 4'd0) begin bad++; $display("FAIL rst_ovf got %b/%0d want 0/0", o_ovf, o_ovf_cnt); end
    vec++; if (o_ready_in !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", o_ready_in); end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_scale_trunc();
    beat(16'sh7FFF, 16'sd3, 16'sh0001, 16'sd0, 1'b1);
    vec++; if (o_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got %b want 1", o_valid); end
    vec++; if (o_re_sum !== 16'sh4000) begin bad++; $display("FAIL half_re_sum got %h want 4000", o_re_sum); end
    vec++; if (o_re_dif !== 16'sh3FFF) begin bad++; $display("FAIL half_re_dif got %h want 3fff", o_re_dif); end
    vec++; if (o_im_sum !== 16'sd1 || o_im_dif !== 16'sd1) begin bad++; $display("FAIL half_im got %0d/%0d want 1/1", o_im_sum, o_im_dif); end
    vec++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL half_ovf got %b want 0", o_ovf); end
    tick();
  endtask

  task automatic test_rounding();
    beat(16'sd3, 16'sd0, 16'sd0, 16'sd0, 1'b1);
    vec++; if (o_re_sum !== 16'sd1) begin bad++; $display("FAIL trunc_pos got %0d want 1", o_re_sum); end
    vec++; if (o_re_sum_r !== 16'sd2) begin bad++; $display("FAIL round_pos got %0d want 2", o_re_sum_r); end
    tick();
    beat(-16'sd3, 16'sd0, 16'sd0, 16'sd0, 1'b1);
    vec++; if (o_re_sum !== -16'sd2) begin bad++; $display("FAIL trunc_neg got %0d want -2", o_re_sum); end
    vec++; if (o_re_sum_r !== -16'sd1) begin bad++; $display("FAIL round_neg got %0d want -1", o_re_sum_r); end
    tick();
  endtask

  task automatic test_saturation();
    beat(16'sh7FFF, 16'sd0, 16'sh0001, 16'sd0, 1'b0);
    vec++; if (o_re_sum !== 16'sh7FFF) begin bad++; $display("FAIL sat_hi_sum got %h want 7fff", o_re_sum); end
    vec++; if (o_re_dif !== 16'sh7FFE) begin bad++; $display("FAIL sat_hi_dif got %h want 7ffe", o_re_dif); end
    vec++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL sat_hi_ovf got %b want 1", o_ovf); end
    tick();
    vec++; if (o_ovf_cnt !== 4'd1) begin bad++; $display("FAIL sat_cnt1 got %0d want 1", o_ovf_cnt); end
    beat(16'sh8000, 16'sd0, 16'sh0001, 16'sd0, 1'b0);
    vec++; if (o_re_dif !== 16'sh8000) begin bad++; $display("FAIL sat_lo_dif got %h want 8000", o_re_dif); end
    vec++; if (o_re_sum !== 16'sh8001) begin bad++; $display("FAIL sat_lo_sum got %h want 8001", o_re_sum); end
    vec++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL sat_lo_ovf got %b want 1", o_ovf); end
    tick();
    vec++; if (o_ovf_cnt !== 4'd2) begin bad++; $display("FAIL sat_cnt2 got %0d want 2", o_ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  pat;
    logic [63:0] prev_out;
    logic [63:0] exp_out;
    logic        prev_stall, acc;
    int sent, recv;
    pat = 4'b1001;
    prev_out = '0; prev_stall = 1'b0; sent = 0; recv = 0;
    for (int c = 0; c < 200 && recv < 8; c++) begin
      i_ready = pat[c % 4];
      i_valid = (sent < 8);
      i_scale = 1'b0;
      i_re_a = 16'(100 * sent + 1); i_im_a = 16'(sent);
      i_re_b = 16'sd7;              i_im_b = 16'sd3;
      #1;
      vec++;
      if (o_ready_in !== !(o_valid && !i_ready)) begin
        bad++; $display("FAIL bp_ready c=%0d got %b valid=%b ready=%b", c, o_ready_in, o_valid, i_ready);
      end
      if (prev_stall) begin
        vec++;
        if (o_valid !== 1'b1 || out_now !== prev_out) begin
          bad++; $display("FAIL bp_hold c=%0d got %h want %h", c, out_now, prev_out);
        end
      end
      if (o_valid && i_ready) begin
        exp_out = {16'(100 * recv + 8), 16'(recv + 3), 16'(100 * recv - 6), 16'(recv - 3)};
        vec++;
        if (out_now !== exp_out) begin
          bad++; $display("FAIL bp_data n=%0d got %h want %h", recv, out_now, exp_out);
        end
        recv++;
      end
      prev_stall = o_valid && !i_ready;
      prev_out = out_now;
      acc = i_valid && o_ready_in;
      tick();
      if (acc) sent++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    vec++; if (recv != 8 || sent != 8) begin bad++; $display("FAIL bp_count got sent=%0d recv=%0d want 8/8", sent, recv); end
    tick();
    vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_extra got valid=%b want 0", o_valid); end
  endtask

  task automatic test_counter();
    i_clr_cnt = 1'b1;
    tick();
    i_clr_cnt = 1'b0;
    vec++; if (o_ovf_cnt !== 4'd0) begin bad++; $display("FAIL cnt_clr got %0d want 0", o_ovf_cnt); end
    drive(16'sh7FFF, 16'sd0, 16'sh0001, 16'sd0, 1'b0);
    repeat (20) tick();
    i_valid = 1'b0;
    repeat (3) tick();
    vec++; if (o_ovf_cnt !== 4'd15) begin bad++; $display("FAIL cnt_sat got %0d want 15", o_ovf_cnt); end
    beat(16'sh7FFF, 16'sd0, 16'sh0001, 16'sd0, 1'b0);
    i_clr_cnt = 1'b1;
    tick();
    i_clr_cnt = 1'b0;
    vec++; if (o_ovf_cnt !== 4'd1) begin bad++; $display("FAIL cnt_clr_inc got %0d want 1", o_ovf_cnt); end
  endtask

  task automatic test_reset_midstream();
    drive(16'sh1234, 16'sh0555, 16'sh0111, 16'sh0222, 1'b0);
    tick();
    drive(16'sh0100, 16'sh0200, 16'sh0300, 16'sh0400, 1'b0);
    tick();
    i_valid = 1'b0;
    vec++; if (o_valid !== 1'b1 || o_re_sum !== 16'sh1345) begin bad++; $display("FAIL mid_pre got %b/%h want 1/1345", o_valid, o_re_sum); end
    #1 rst_n = 1'b0;
    #1;
    vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got %b want 0", o_valid); end
    vec++; if (out_now !== 64'd0 || o_ovf !== 1'b0) begin bad++; $display("FAIL mid_data got %h/%b want 0/0", out_now, o_ovf); end
    vec++; if (o_ovf_cnt !== 4'd0) begin bad++; $display("FAIL mid_cnt got %0d want 0", o_ovf_cnt); end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vec++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_stale k=%0d got %b want 0", k, o_valid); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scale_trunc();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_counter();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/complex_addsub_pipe.md
Name: complex_addsub_pipe

Overview:
- Parametrised, pipelined complex butterfly adder for the FFT datapath.
- Each accepted beat takes two complex samples A and B and produces both A+B and A−B.
- Per-beat scale mode: halve with truncate/round, or keep full scale with saturation.
- Valid/ready handshake with backpressure; overflow is flagged per beat and counted in a saturating counter for the FFT block-scaling controller.

Parameters:
- DW, 16: sample width (signed two's complement) for all real/imag inputs and outputs; legal 4..32.
- PIPE, 2: register stages from input acceptance to output; legal 1..4.
- ROUND, 0: applies when scale=1. 0 = truncate (floor); 1 = round half up (add 1 before shift).
- OCW, 8: overflow counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready_in  out  1  block can accept a beat this cycle
- i_scale  in  1  1 = result>>1; 0 = full scale, saturated
- i_re_a  in  DW  A real
- i_im_a  in  DW  A imaginary
- i_re_b  in  DW  B real
- i_im_b  in  DW  B imaginary
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output
- o_re_sum  out  DW  Re(A+B)
- o_im_sum  out  DW  Im(A+B)
- o_re_dif  out  DW  Re(A−B)
- o_im_dif  out  DW  Im(A−B)
- o_ovf  out  1  at least one of the 4 results saturated this beat
- i_clr_cnt  in  1  synchronous clear of overflow counter
- o_ovf_cnt  out  OCW  saturating count of beats with o_ovf=1

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valids=0, o_valid=0, all data outputs=0, o_ovf=0, o_ovf_cnt=0. Reset mid-operation discards in-flight beats; no beat emerges after release.
- Global stall: en = i_ready | ~o_valid. o_ready_in = en (combinational). A beat is accepted when i_valid & o_ready_in.
- When en=1, every stage advances and each stage valid shifts. When en=0, all stages and outputs hold unchanged.
- Latency: PIPE cycles from acceptance to o_valid with no stall. Throughput: 1 beat/cycle. Order preserved; no beat dropped or duplicated.
- Arithmetic: 4 sums/differences in DW+1 bits, sign-extended.
  - scale=1, ROUND=0: result = s>>>1, i.e. bits [DW:1]. Never overflows.
  - scale=1, ROUND=1: result = (s+1)>>>1, computed in DW+2 bits. Never overflows; range fits DW.
  - scale=0: clamp s to [−2^(DW−1), 2^(DW−1)−1].
- o_ovf = OR of the 4 clamp events. It is 0 whenever scale=1, and travels aligned with its beat.
- i_scale is sampled with the beat and carried through the pipe.
- Counter increments once per output handshake (o_valid & i_ready) with o_ovf=1. It saturates at 2^OCW−1 and never wraps.
- Counter clear: if i_clr_cnt=1 and an increment occur in the same cycle, the result is 1. i_clr_cnt alone gives 0.
- Outputs are registered. Data outputs hold their last value while o_valid=0.

Test Plan:
- DW=16, PIPE=2, scale=1, ROUND=0, re_a=0x7FFF, re_b=0x0001, im_a=3, im_b=0 → after 2 cycles:
  - o_re_sum=0x4000, o_re_dif=0x3FFF, o_im_sum=1, o_im_dif=1, o_ovf=0.
- Rounding, scale=1, re_a=3, re_b=0 then re_a=−3, re_b=0:
  - ROUND=0 gives o_re_sum=1, then −2.
  - ROUND=1 gives o_re_sum=2, then −1.
- Saturation, scale=0:
  - re_a=0x7FFF, re_b=0x0001 → o_re_sum=0x7FFF, o_re_dif=0x7FFE, o_ovf=1, count=1.
  - re_a=0x8000, re_b=0x0001 → o_re_dif=0x8000, o_ovf=1, count=2.
- Backpressure: stream 8 beats with i_ready toggling 1,0,0,1,… →
  - all 8 outputs appear in order with no loss or duplication.
  - o_ready_in=0 exactly when o_valid=1 and i_ready=0.
  - outputs are stable while stalled.
- Counter: OCW=4, 20 overflowing beats → o_ovf_cnt=15. Then i_clr_cnt during an overflowing handshake → 1.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight → o_valid=0 and outputs=0 immediately; after release, no stale beat appears.
